// File: rtl/cmsdk_sram16_pkg.sv
// Shared types and constants for the AHB to 16-bit async SRAM controller.
package cmsdk_sram16_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_WHOLD = 3'd3,
    ST_TURN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Access shape derived from HSIZE/HADDR at acceptance
  typedef struct packed {
    logic word;  // two 16-bit accesses
    logic half;  // first half to access
    logic lbn;   // low byte lane strobe
    logic ubn;   // high byte lane strobe
  } req_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans != HTRANS_IDLE) && (htrans[1] == HTRANS_NONSEQ[1]);
  endfunction

  // Sizes above word are treated as word; address aligned down to the size
  function automatic req_t decode_req(input logic [2:0] size, input logic [1:0] addr_lo);
    req_t r;
    r = '0;
    if (size == HSIZE_BYTE) begin
      r.half = addr_lo[1];
      r.lbn  = addr_lo[0];
      r.ubn  = ~addr_lo[0];
    end else if (size == HSIZE_HALF) begin
      r.half = addr_lo[1];
    end else begin
      r.word = 1'b1;
    end
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && addr_lo[0]) ||
           ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/cmsdk_sram16_wait_cnt.sv
// Loadable down-counter with zero flag, shared by read, write and turnaround timing.
module cmsdk_sram16_wait_cnt
  import cmsdk_sram16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmsdk_ahb_sram16_ctrl.sv
// AHB-Lite slave driving one asynchronous 16-bit SRAM.
// Build option: define CMSDK_SRAM16_ALIGN_CHECK_EN to answer misaligned or
// oversized transfers with a two-cycle ERROR instead of aligning them down.
module cmsdk_ahb_sram16_ctrl
  import cmsdk_sram16_pkg::*;
#(
  parameter int unsigned AW         = 18,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 2,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [15:0]   MEM_DATA_I,
  output logic [15:0]   MEM_DATA_O,
  output logic          MEM_DATA_OE,
  output logic          MEM_WEn,
  output logic          MEM_OEn,
  output logic          MEM_CEn,
  output logic          MEM_LBn,
  output logic          MEM_UBn
);

  state_e           state_q;
  logic [AW-3:0]    addr_hi_q;
  logic             half_q;
  logic             word_q;
  logic             lane_lbn_q;
  logic             lane_ubn_q;
  logic             last_rd_q;
  logic             hreadyout_q;
  logic             hresp_q;
  logic [31:0]      hrdata_q;
  logic [15:0]      rd_lo_q;
  logic             cen_q;
  logic             oen_q;
  logic             wen_q;
  logic             lbn_q;
  logic             ubn_q;
  logic             oe_q;

  req_t             req_c;
  logic             err_c;
  logic             acc_c;
  logic             go_turn_c;
  logic             more_c;
  logic             enter_rd_c;
  logic             enter_wr_c;
  logic             enter_turn_c;
  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             cnt_zero;

  // Acceptance decode, state-entry conditions and wait-counter control
  always_comb begin
    req_c = decode_req(HSIZE, HADDR[1:0]);
`ifdef CMSDK_SRAM16_ALIGN_CHECK_EN
    err_c = misaligned(HSIZE, HADDR[1:0]);
`else
    err_c = 1'b0;
`endif
    acc_c        = HSEL & HREADY & trans_active(HTRANS) &
                   ((state_q == ST_IDLE) | (state_q == ST_DONE));
    go_turn_c    = HWRITE & last_rd_q & (TURNAROUND != 0);
    more_c       = word_q & ~half_q;
    enter_rd_c   = (acc_c & ~err_c & ~HWRITE) |
                   ((state_q == ST_RD) & cnt_zero & more_c);
    enter_turn_c = acc_c & ~err_c & go_turn_c;
    enter_wr_c   = (acc_c & ~err_c & HWRITE & ~go_turn_c) |
                   ((state_q == ST_WHOLD) & more_c) |
                   ((state_q == ST_TURN) & cnt_zero);
    cnt_load_c   = enter_rd_c | enter_wr_c | enter_turn_c;
    cnt_val_c    = '0;
    if (enter_rd_c) begin
      cnt_val_c = CNT_W'(RD_WAIT);
    end else if (enter_wr_c) begin
      cnt_val_c = CNT_W'(WR_WAIT);
    end else if (enter_turn_c) begin
      cnt_val_c = CNT_W'(TURNAROUND - 1);
    end
    cnt_dec_c = (state_q inside {ST_RD, ST_WR, ST_TURN});
  end

  cmsdk_sram16_wait_cnt u_wait_cnt (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .dec_i      (cnt_dec_c),
    .zero_o     (cnt_zero)
  );

  // Access sequencer with registered bus response and SRAM strobes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= '0;
      half_q      <= 1'b0;
      word_q      <= 1'b0;
      lane_lbn_q  <= 1'b1;
      lane_ubn_q  <= 1'b1;
      last_rd_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      rd_lo_q     <= '0;
      cen_q       <= 1'b1;
      oen_q       <= 1'b1;
      wen_q       <= 1'b1;
      lbn_q       <= 1'b1;
      ubn_q       <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (acc_c) begin
            addr_hi_q   <= HADDR[AW-1:2];
            half_q      <= req_c.half;
            word_q      <= req_c.word;
            lane_lbn_q  <= req_c.lbn;
            lane_ubn_q  <= req_c.ubn;
            hreadyout_q <= 1'b0;
            hresp_q     <= err_c;
            if (err_c) begin
              state_q <= ST_ERR;
            end else if (enter_turn_c) begin
              state_q <= ST_TURN;
            end else if (HWRITE) begin
              state_q <= ST_WR;
              cen_q   <= 1'b0;
              wen_q   <= 1'b0;
              oe_q    <= 1'b1;
              lbn_q   <= req_c.lbn;
              ubn_q   <= req_c.ubn;
            end else begin
              state_q <= ST_RD;
              cen_q   <= 1'b0;
              oen_q   <= 1'b0;
              lbn_q   <= req_c.lbn;
              ubn_q   <= req_c.ubn;
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        ST_RD: begin
          if (cnt_zero) begin
            if (more_c) begin
              rd_lo_q <= MEM_DATA_I;
              half_q  <= 1'b1;
            end else begin
              hrdata_q    <= word_q ? {MEM_DATA_I, rd_lo_q} : {MEM_DATA_I, MEM_DATA_I};
              state_q     <= ST_DONE;
              hreadyout_q <= 1'b1;
              last_rd_q   <= 1'b1;
              cen_q       <= 1'b1;
              oen_q       <= 1'b1;
              lbn_q       <= 1'b1;
              ubn_q       <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (cnt_zero) begin
            state_q <= ST_WHOLD;
            wen_q   <= 1'b1;
          end
        end
        ST_WHOLD: begin
          if (more_c) begin
            state_q <= ST_WR;
            half_q  <= 1'b1;
            wen_q   <= 1'b0;
          end else begin
            state_q     <= ST_DONE;
            hreadyout_q <= 1'b1;
            last_rd_q   <= 1'b0;
            cen_q       <= 1'b1;
            oe_q        <= 1'b0;
            lbn_q       <= 1'b1;
            ubn_q       <= 1'b1;
          end
        end
        ST_TURN: begin
          if (cnt_zero) begin
            state_q <= ST_WR;
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            oe_q    <= 1'b1;
            lbn_q   <= lane_lbn_q;
            ubn_q   <= lane_ubn_q;
          end
        end
        ST_ERR: begin
          state_q     <= ST_DONE;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Write data follows HWDATA directly: it is only valid in the data phase,
  // which already covers the first WEn-low cycle of the access.
  assign MEM_DATA_O  = oe_q ? (half_q ? HWDATA[31:16] : HWDATA[15:0]) : 16'h0000;
  assign MEM_DATA_OE = oe_q;
  assign MEM_ADDR    = {addr_hi_q, half_q, 1'b0};
  assign MEM_WEn     = wen_q;
  assign MEM_OEn     = oen_q;
  assign MEM_CEn     = cen_q;
  assign MEM_LBn     = lbn_q;
  assign MEM_UBn     = ubn_q;
  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign HRDATA      = hrdata_q;

endmodule

// File: tb/tb_cmsdk_ahb_sram16_ctrl.sv
// Directed bench for cmsdk_ahb_sram16_ctrl with a behavioural async SRAM.
module tb_cmsdk_ahb_sram16_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [17:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [17:0] MEM_ADDR;
  logic [15:0] MEM_DATA_I = 16'h0000;
  logic [15:0] MEM_DATA_O;
  logic        MEM_DATA_OE;
  logic        MEM_WEn, MEM_OEn, MEM_CEn, MEM_LBn, MEM_UBn;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  typedef struct packed {
    logic        hreadyout;
    logic        hresp;
    logic        wen;
    logic        oen;
    logic        cen;
    logic        lbn;
    logic        ubn;
    logic        oe;
    logic [17:0] addr;
  } smp_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
    logic        lbn;
    logic        ubn;
  } wr_t;

  smp_t        trace[$];
  wr_t         wr_log[$];
  logic [15:0] sram [logic [16:0]];

  always #5 HCLK = ~HCLK;

  cmsdk_ahb_sram16_ctrl #(
    .AW(18), .RD_WAIT(1), .WR_WAIT(2), .TURNAROUND(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA_I(MEM_DATA_I), .MEM_DATA_O(MEM_DATA_O),
    .MEM_DATA_OE(MEM_DATA_OE), .MEM_WEn(MEM_WEn), .MEM_OEn(MEM_OEn),
    .MEM_CEn(MEM_CEn), .MEM_LBn(MEM_LBn), .MEM_UBn(MEM_UBn)
  );

  // SRAM read path: data presented while chip and output enables are low
  always @(negedge HCLK) begin
    if (!MEM_CEn && !MEM_OEn)
      MEM_DATA_I = sram.exists(MEM_ADDR[17:1]) ? sram[MEM_ADDR[17:1]] : 16'h0000;
    else
      MEM_DATA_I = 16'hDEAD;
  end

  // SRAM write path: lanes latched on the rising edge of WEn
  always @(posedge MEM_WEn) begin
    logic [15:0] w;
    if (HRESETn && !MEM_CEn) begin
      w = sram.exists(MEM_ADDR[17:1]) ? sram[MEM_ADDR[17:1]] : 16'h0000;
      if (!MEM_LBn) w[7:0]  = MEM_DATA_O[7:0];
      if (!MEM_UBn) w[15:8] = MEM_DATA_O[15:8];
      sram[MEM_ADDR[17:1]] = w;
      wr_log.push_back('{addr: MEM_ADDR, data: MEM_DATA_O, lbn: MEM_LBn, ubn: MEM_UBn});
    end
  end

  // Pin-level protocol hazards
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (!MEM_OEn && !MEM_WEn) viol++;
      if (MEM_DATA_OE && !MEM_OEn) viol++;
    end
  end

  function automatic smp_t sample();
    smp_t s;
    s.hreadyout = HREADYOUT;
    s.hresp     = HRESP;
    s.wen       = MEM_WEn;
    s.oen       = MEM_OEn;
    s.cen       = MEM_CEn;
    s.lbn       = MEM_LBn;
    s.ubn       = MEM_UBn;
    s.oe        = MEM_DATA_OE;
    s.addr      = MEM_ADDR;
    return s;
  endfunction

  // One AHB transfer; returns read data and data-phase length in cycles
  task automatic xfer(input logic wr, input logic [17:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int cycles);
    logic done;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    trace.delete();
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 64) begin
      #1;
      cycles++;
      trace.push_back(sample());
      if (HREADYOUT) done = 1'b1;
      else @(negedge HCLK);
    end
    rdata = HRDATA;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout: got %b want 1", HREADYOUT); end
    n_cmp++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL rst_hresp: got %b want 0", HRESP); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", HRDATA); end
    n_cmp++; if (MEM_ADDR !== 18'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", MEM_ADDR); end
    n_cmp++; if ({MEM_DATA_OE, MEM_DATA_O} !== 17'h0) begin n_err++; $display("FAIL rst_data: got oe=%b d=%h want 0/0000", MEM_DATA_OE, MEM_DATA_O); end
    n_cmp++; if ({MEM_WEn, MEM_OEn, MEM_CEn, MEM_LBn, MEM_UBn} !== 5'b11111) begin
      n_err++; $display("FAIL rst_strobes: got %b want 11111", {MEM_WEn, MEM_OEn, MEM_CEn, MEM_LBn, MEM_UBn});
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_word_write_read();
    logic [31:0] rd;
    int cyc;
    wr_log.delete();
    xfer(1'b1, 18'h00010, 3'd2, 32'hA5A5_1234, rd, cyc);
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL wword_cycles: got %0d want 9", cyc); end
    n_cmp++; if (wr_log.size() != 2) begin n_err++; $display("FAIL wword_count: got %0d want 2", wr_log.size()); end
    else begin
      n_cmp++; if ({wr_log[0].addr, wr_log[0].data, wr_log[0].lbn, wr_log[0].ubn} !== {18'h00010, 16'h1234, 2'b00}) begin
        n_err++; $display("FAIL wword_lo: got %h/%h/%b%b want 00010/1234/00", wr_log[0].addr, wr_log[0].data, wr_log[0].lbn, wr_log[0].ubn);
      end
      n_cmp++; if ({wr_log[1].addr, wr_log[1].data, wr_log[1].lbn, wr_log[1].ubn} !== {18'h00012, 16'hA5A5, 2'b00}) begin
        n_err++; $display("FAIL wword_hi: got %h/%h/%b%b want 00012/a5a5/00", wr_log[1].addr, wr_log[1].data, wr_log[1].lbn, wr_log[1].ubn);
      end
    end
    xfer(1'b0, 18'h00010, 3'd2, 32'h0, rd, cyc);
    n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL rword_cycles: got %0d want 5", cyc); end
    n_cmp++; if (rd !== 32'hA5A5_1234) begin n_err++; $display("FAIL rword_data: got %h want a5a51234", rd); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd;
    int cyc;
    repeat (2) @(negedge HCLK);
    wr_log.delete();
    xfer(1'b1, 18'h00023, 3'd0, 32'h7700_0000, rd, cyc);
    n_cmp++; if (cyc != 6) begin n_err++; $display("FAIL wbyte_cycles: got %0d want 6", cyc); end
    n_cmp++; if (wr_log.size() != 1) begin n_err++; $display("FAIL wbyte_count: got %0d want 1", wr_log.size()); end
    else begin
      n_cmp++; if ({wr_log[0].addr, wr_log[0].lbn, wr_log[0].ubn} !== {18'h00022, 2'b10}) begin
        n_err++; $display("FAIL wbyte_lane: got %h/%b%b want 00022/10", wr_log[0].addr, wr_log[0].lbn, wr_log[0].ubn);
      end
      n_cmp++; if (wr_log[0].data[15:8] !== 8'h77) begin n_err++; $display("FAIL wbyte_data: got %h want 77", wr_log[0].data[15:8]); end
    end
    xfer(1'b0, 18'h00022, 3'd1, 32'h0, rd, cyc);
    n_cmp++; if ({cyc[7:0], rd} !== {8'd3, 32'h7700_7700}) begin
      n_err++; $display("FAIL rbyte_back: got %0d/%h want 3/77007700", cyc, rd);
    end
  endtask

  task automatic test_turnaround();
    logic [31:0] rd;
    int cyc;
    int n_turn;
    sram[17'h00080] = 16'h3333;
    sram[17'h00081] = 16'h4444;
    xfer(1'b0, 18'h00100, 3'd2, 32'h0, rd, cyc);
    n_cmp++; if ({cyc[7:0], rd} !== {8'd5, 32'h4444_3333}) begin
      n_err++; $display("FAIL turn_read: got %0d/%h want 5/44443333", cyc, rd);
    end
    xfer(1'b1, 18'h00104, 3'd2, 32'h1111_2222, rd, cyc);
    n_cmp++; if (cyc != 10) begin n_err++; $display("FAIL turn_wcycles: got %0d want 10", cyc); end
    n_turn = 0;
    foreach (trace[i]) begin
      if (trace[i].wen === 1'b0) break;
      if ({trace[i].wen, trace[i].oen, trace[i].cen, trace[i].lbn, trace[i].ubn, trace[i].oe} === 6'b111110) n_turn++;
    end
    n_cmp++; if (n_turn != 1) begin n_err++; $display("FAIL turn_idle: got %0d want 1", n_turn); end
    n_cmp++; if (trace.size() < 2 || trace[1].wen !== 1'b0) begin n_err++; $display("FAIL turn_wen: WEn not low in cycle 2"); end
    n_cmp++; if (HRDATA !== 32'h4444_3333) begin n_err++; $display("FAIL turn_hold: got %h want 44443333", HRDATA); end
  endtask

  task automatic test_pipelined_half();
    logic [31:0] rd;
    int cyc;
    xfer(1'b1, 18'h00200, 3'd1, 32'h0000_BEEF, rd, cyc);
    n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL whalf0_cycles: got %0d want 5", cyc); end
    xfer(1'b1, 18'h00202, 3'd1, 32'hCAFE_0000, rd, cyc);
    n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL whalf1_cycles: got %0d want 5", cyc); end
    xfer(1'b0, 18'h00200, 3'd1, 32'h0, rd, cyc);
    n_cmp++; if ({cyc[7:0], rd} !== {8'd3, 32'hBEEF_BEEF}) begin
      n_err++; $display("FAIL rhalf0: got %0d/%h want 3/beefbeef", cyc, rd);
    end
    xfer(1'b0, 18'h00202, 3'd1, 32'h0, rd, cyc);
    n_cmp++; if ({cyc[7:0], rd} !== {8'd3, 32'hCAFE_CAFE}) begin
      n_err++; $display("FAIL rhalf1: got %0d/%h want 3/cafecafe", cyc, rd);
    end
    n_cmp++; if ({trace[0].cen, trace[0].oen, trace[0].addr} !== {2'b00, 18'h00202}) begin
      n_err++; $display("FAIL rhalf1_start: got cen=%b oen=%b addr=%h want 0/0/00202", trace[0].cen, trace[0].oen, trace[0].addr);
    end
  endtask

  task automatic test_misaligned_half();
    logic [31:0] rd;
    int cyc;
    int n_act;
    wr_log.delete();
    xfer(1'b1, 18'h00201, 3'd1, 32'h0000_5A5A, rd, cyc);
`ifdef CMSDK_SRAM16_ALIGN_CHECK_EN
    n_cmp++; if (cyc != 2) begin n_err++; $display("FAIL err_cycles: got %0d want 2", cyc); end
    n_cmp++; if ({trace[0].hreadyout, trace[0].hresp, HREADYOUT, HRESP} !== 4'b0111) begin
      n_err++; $display("FAIL err_resp: got %b%b %b%b want 01 11", trace[0].hreadyout, trace[0].hresp, HREADYOUT, HRESP);
    end
    n_act = 0;
    foreach (trace[i]) if ({trace[i].wen, trace[i].oen, trace[i].cen} !== 3'b111) n_act++;
    n_cmp++; if (n_act + wr_log.size() != 0) begin n_err++; $display("FAIL err_strobes: got %0d active want 0", n_act + wr_log.size()); end
    @(negedge HCLK);
`else
    n_act = 0;
    foreach (trace[i]) if (trace[i].hresp !== 1'b0) n_act++;
    n_cmp++; if (cyc != 6) begin n_err++; $display("FAIL mis_cycles: got %0d want 6", cyc); end
    n_cmp++; if (n_act != 0) begin n_err++; $display("FAIL mis_hresp: got %0d error cycles want 0", n_act); end
    n_cmp++; if (wr_log.size() != 1) begin n_err++; $display("FAIL mis_count: got %0d want 1", wr_log.size()); end
    else begin
      n_cmp++; if ({wr_log[0].addr, wr_log[0].data, wr_log[0].lbn, wr_log[0].ubn} !== {18'h00200, 16'h5A5A, 2'b00}) begin
        n_err++; $display("FAIL mis_write: got %h/%h/%b%b want 00200/5a5a/00", wr_log[0].addr, wr_log[0].data, wr_log[0].lbn, wr_log[0].ubn);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    int waited;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 18'h00300; HSIZE = 3'd2; HWRITE = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BAD_F00D;
    waited = 0;
    while (MEM_WEn !== 1'b0 && waited < 6) begin @(negedge HCLK); waited++; end
    n_cmp++; if (MEM_WEn !== 1'b0) begin n_err++; $display("FAIL rmid_pre: got WEn=%b want 0", MEM_WEn); end
    #2 HRESETn = 1'b0;
    #1;
    n_cmp++; if ({MEM_WEn, MEM_CEn} !== 2'b11) begin n_err++; $display("FAIL rmid_strobes: got WEn/CEn=%b%b want 11", MEM_WEn, MEM_CEn); end
    n_cmp++; if (MEM_DATA_OE !== 1'b0) begin n_err++; $display("FAIL rmid_oe: got %b want 0", MEM_DATA_OE); end
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", HREADYOUT); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_cmp++; if ({HRDATA, MEM_ADDR} !== 50'h0) begin n_err++; $display("FAIL rmid_after: got %h/%h want 0/0", HRDATA, MEM_ADDR); end
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_turnaround();
    test_pipelined_half();
    test_misaligned_half();
    test_reset_mid_write();
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL pin_hazard: got %0d violations want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmsdk_ahb_sram16_ctrl.md
Name: cmsdk_ahb_sram16_ctrl

Overview:
- AHB-Lite slave that drives one external asynchronous 16-bit SRAM. Pins: address, bidirectional data split into in/out/oe, WEn, OEn, CEn, LBn, UBn.
- A 32-bit AHB word is split into two sequential 16-bit memory accesses; byte and halfword accesses take one access.
- Programmable read/write wait states and a bus-turnaround counter. Sits between the AHB bus matrix and the board-level SRAM pads.

Parameters:
AW, 18, memory byte-address width; MEM_ADDR bit 0 is always 0
RD_WAIT, 1, extra cycles of OEn low per read access (0..15)
WR_WAIT, 2, extra cycles of WEn low per write access (0..15)
TURNAROUND, 1, idle cycles between a read access and a following write access (0..3)

Ports:
HCLK  input  1  single clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select
HADDR  input  AW  byte address
HTRANS  input  2  transfer type; bit 1 = NONSEQ/SEQ
HSIZE  input  3  0=byte, 1=half, 2=word
HWRITE  input  1  write when 1
HWDATA  input  32  write data, valid in data phase
HREADY  input  1  bus ready
HREADYOUT  output  1  slave ready
HRDATA  output  32  read data
HRESP  output  1  0=OKAY, 1=ERROR
MEM_ADDR  output  AW  SRAM address
MEM_DATA_I  input  16  SRAM read data from pad
MEM_DATA_O  output  16  SRAM write data to pad
MEM_DATA_OE  output  1  pad output enable, high only while writing
MEM_WEn, MEM_OEn, MEM_CEn, MEM_LBn, MEM_UBn  output  1 each  SRAM strobes, active low

Behaviour:
- Interface: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset (asynchronous, also mid-operation) forces:
  - HREADYOUT=1, HRESP=0, HRDATA=0, MEM_ADDR=0.
  - MEM_DATA_O=0, MEM_DATA_OE=0.
  - All strobes =1.
  - FSM to IDLE, counters 0. Any in-flight access is abandoned.
- Transfer accepted when HSEL & HREADY & HTRANS[1]. HADDR/HSIZE/HWRITE are registered at that edge. IDLE/BUSY or unselected transfers get a zero-wait OKAY.
- FSM states: IDLE, RD, WR, WHOLD, TURN, DONE.
  - IDLE -> RD (read) or WR (write). Goes via TURN instead if the previous access was a read, the new one is a write, and TURNAROUND>0.
  - RD: CEn=0, OEn=0 for RD_WAIT+1 cycles. MEM_DATA_I is sampled on the last cycle into the current half register.
  - WR: CEn=0, WEn=0, MEM_DATA_OE=1 for WR_WAIT+1 cycles.
  - WHOLD: one cycle with WEn=1, CEn=0, data and OE still driven (hold time).
  - After the low half of a word, the FSM re-enters RD/WR for the high half at MEM_ADDR+2.
  - DONE: HREADYOUT=1 for one cycle. A pipelined next transfer accepted in DONE starts directly in the following cycle.
- HREADYOUT is 0 from the cycle after acceptance until DONE.
- Data-phase length:
  - Read: halves*(RD_WAIT+1)+1 cycles.
  - Write: halves*(WR_WAIT+2)+1 cycles.
  - Plus TURN cycles when TURN is entered.
- Lanes:
  - MEM_ADDR = {addr[AW-1:2], half, 1'b0}.
  - Byte access: LBn=0 if addr[0]=0, else UBn=0.
  - Half or word access: both LBn and UBn = 0.
  - MEM_DATA_O = HWDATA[15:0] for half 0, HWDATA[31:16] for half 1; half = addr[1] for sub-word accesses.
- HRDATA:
  - Word read: {hi, lo}.
  - Sub-word read: the 16-bit value read is replicated into both halves.
  - HRDATA is held until the next read completes.
- Strobes are never low together with MEM_DATA_OE while OEn is low. OEn and WEn are never both 0.

Optional Feature:
- Macro: CMSDK_SRAM16_ALIGN_CHECK_EN.
- Defined: HSIZE>2, a halfword with addr[0]=1, or a word with addr[1:0]!=0 gets a two-cycle ERROR response with no SRAM strobes. Cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
- Undefined: HRESP is tied to 0. The address is aligned down to the access size, and HSIZE>2 is treated as word.

Decomposition:
- Package cmsdk_sram16_pkg holds:
  - FSM state enum.
  - HTRANS constants (IDLE=2'b00, NONSEQ=2'b10) and HSIZE constants (BYTE/HALF/WORD).
  - Counter width constant (4 bits).
- Sub-module cmsdk_sram16_wait_cnt: loadable down-counter with a zero flag, instantiated once. It is shared by the RD, WR and TURN states.

Test Plan:
- Reset mid-write (WR state, WEn=0) -> same cycle: WEn=1, CEn=1, MEM_DATA_OE=0, HREADYOUT=1.
- Word write 0xA5A5_1234 to 0x00010, then word read of the same address, RD_WAIT=1, WR_WAIT=2, TURNAROUND=1:
  - Write: MEM_ADDR 0x00010 with data 0x1234, then 0x00012 with data 0xA5A5; write data phase 9 cycles.
  - Read: HRDATA=0xA5A5_1234 after 5 data-phase cycles.
- Byte write 0x77 (HWDATA=0x7700_0000) to 0x00023 -> one access: MEM_ADDR 0x00022, UBn=0, LBn=1, MEM_DATA_O[15:8]=0x77.
- Read at 0x00100 then write at 0x00104 back-to-back -> exactly 1 TURN cycle with all strobes high and OE=0 before WEn falls.
- Pipelined halfword reads 0x00200, 0x00202 -> second access starts the cycle after the first DONE. Each data phase is 3 cycles; HRDATA is the replicated halfword.
- Halfword write to 0x00201:
  - With CMSDK_SRAM16_ALIGN_CHECK_EN: ERROR response, no strobe activity.
  - Without: write to 0x00200, both lanes enabled.
